// File: rtl/crc_tx_arbiter.sv
// Round-robin arbiter that shares one bit-serial CRC-32 generator among NUM_REQ frame sources.
// Grants one source per frame, forwards its bits, then holds everyone off for the FCS tail and gap.
module crc_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int TAIL_CYCLES   = 32,
  parameter int GAP_CYCLES    = 4,
  parameter int START_TIMEOUT = 15,
  parameter int LEN_W         = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_bit_vld,
  input  logic [NUM_REQ-1:0] i_bit,
  input  logic [NUM_REQ-1:0] i_bit_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_crc_in_vld,
  output logic               o_crc_in,
  input  logic               i_eng_out_vld,
  output logic               o_busy,
  output logic               o_done,
  output logic [ID_W-1:0]    o_done_id,
  output logic [LEN_W-1:0]   o_frame_bits,
  output logic               o_err_underrun,
  output logic               o_err_timeout
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int MAX_A   = (TAIL_CYCLES > GAP_CYCLES) ? TAIL_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_A > START_TIMEOUT) ? MAX_A : START_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TAIL_LD = CNT_W'(TAIL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(START_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_TAIL = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   bits_q, bits_d;
  logic               vld_q, vld_d;
  logic               crc_q, crc_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [LEN_W-1:0]   fbits_q, fbits_d;
  logic               und_q, und_d;
  logic               to_q, to_d;

  logic               pick_vld;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    pick_nxt;
  int                 scan_idx;
  logic [IDX_W-1:0]   g_sel;
  logic               g_vld, g_bit, g_last;

  // Search upward from the pointer, wrapping, for the first pending request.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    pick_nxt = '0;
    scan_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!pick_vld && i_req[IDX_W'(scan_idx)]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(scan_idx);
        pick_nxt = (scan_idx == NUM_REQ - 1) ? '0 : ID_W'(scan_idx + 1);
      end
    end
  end

  assign g_sel  = IDX_W'(gid_q);
  assign g_vld  = i_bit_vld[g_sel];
  assign g_bit  = i_bit[g_sel];
  assign g_last = i_bit_last[g_sel];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    vld_d     = 1'b0;
    crc_d     = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    fbits_d   = fbits_q;
    und_d     = 1'b0;
    to_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = NUM_REQ'(1) << pick_id;
          gid_d   = pick_id;
          ptr_d   = pick_nxt;
          cnt_d   = TO_LD;
          bits_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT, S_DATA: begin
        if (g_vld) begin
          vld_d = 1'b1;
          crc_d = g_bit;
          if (bits_q != {LEN_W{1'b1}}) bits_d = bits_q + LEN_W'(1);
          if (g_last) begin
            gnt_d   = '0;
            cnt_d   = TAIL_LD;
            state_d = S_TAIL;
          end else begin
            state_d = S_DATA;
          end
        end else if (state_q == S_DATA) begin
          und_d   = 1'b1;
          gnt_d   = '0;
          cnt_d   = TAIL_LD;
          state_d = S_TAIL;
        end else if (cnt_q == '0) begin
          to_d    = 1'b1;
          gnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_TAIL: begin
        // The tail count only starts once the generator sees valid low.
        if (!vld_q) begin
          if (cnt_q == '0) begin
            cnt_d   = GAP_LD;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!i_eng_out_vld) begin
          done_d    = 1'b1;
          done_id_d = gid_q;
          fbits_d   = bits_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gid_q     <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      bits_q    <= '0;
      vld_q     <= 1'b0;
      crc_q     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      fbits_q   <= '0;
      und_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      vld_q     <= vld_d;
      crc_q     <= crc_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      fbits_q   <= fbits_d;
      und_q     <= und_d;
      to_q      <= to_d;
    end
  end

  assign o_gnt          = gnt_q;
  assign o_crc_in_vld   = vld_q;
  assign o_crc_in       = crc_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = done_q;
  assign o_done_id      = done_id_q;
  assign o_frame_bits   = fbits_q;
  assign o_err_underrun = und_q;
  assign o_err_timeout  = to_q;

endmodule

// File: tb/tb_crc_tx_arbiter.sv
// Bench for crc_tx_arbiter: directed frame table, randomized frames against a timeline model,
// and an asynchronous reset in the middle of a frame.
module tb_crc_tx_arbiter;
  localparam int N = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  i_req = '0;
  logic [3:0]  i_bit_vld = '0;
  logic [3:0]  i_bit = '0;
  logic [3:0]  i_bit_last = '0;
  logic        i_eng_out_vld = 1'b0;
  logic [3:0]  o_gnt;
  logic        o_crc_in_vld;
  logic        o_crc_in;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_done_id;
  logic [15:0] o_frame_bits;
  logic        o_err_underrun;
  logic        o_err_timeout;

  always #5 i_clk = ~i_clk;

  crc_tx_arbiter dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_req          (i_req),
    .i_bit_vld      (i_bit_vld),
    .i_bit          (i_bit),
    .i_bit_last     (i_bit_last),
    .o_gnt          (o_gnt),
    .o_crc_in_vld   (o_crc_in_vld),
    .o_crc_in       (o_crc_in),
    .i_eng_out_vld  (i_eng_out_vld),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_done_id      (o_done_id),
    .o_frame_bits   (o_frame_bits),
    .o_err_underrun (o_err_underrun),
    .o_err_timeout  (o_err_timeout)
  );

  typedef struct {
    logic [3:0]  mask;
    int          dly;
    int          len;
    int          und;
    int          ext;
    logic [15:0] bits;
    int          exp_id;
    string       name;
  } vec_t;

  vec_t tbl[12];
  int   checks = 0;
  int   errors = 0;
  int   ptr_m = 0;
  int   prev_id_m = 0;
  int   prev_bits_m = 0;

  function automatic int rr_pick(input logic [3:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[2'((ptr_m + i) % N)]) return (ptr_m + i) % N;
    end
    return 0;
  endfunction

  task automatic check_out(input string name, input logic [3:0] g, input logic v, input logic c,
                           input logic b, input logic d, input logic eu, input logic et,
                           input int did, input int fb);
    logic [27:0] act;
    logic [27:0] exp;
    act = {o_gnt, o_crc_in_vld, (v ? o_crc_in : 1'b0), o_busy, o_done, o_err_underrun,
           o_err_timeout, o_done_id, o_frame_bits};
    exp = {g, v, c, b, d, eu, et, 2'(did), 16'(fb)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got gnt/vld/crc/busy/done/eu/et/id/bits=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic set_lanes(input logic [1:0] gi, input logic v, input logic b, input logic l,
                           input bit own);
    i_bit_vld  = 4'($urandom);
    i_bit      = 4'($urandom);
    i_bit_last = 4'($urandom);
    if (own) begin
      i_bit_vld[gi]  = v;
      i_bit[gi]      = b;
      i_bit_last[gi] = l;
    end
  endtask

  task automatic idle_cycles(input int k);
    i_req = '0;
    for (int r = 0; r < k; r++) begin
      set_lanes(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge i_clk);
      check_out("idle", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, prev_id_m, prev_bits_m);
    end
  endtask

  // Timeline model: relative to the IDLE cycle where the request is applied, every output is
  // derived from grant latency, start delay, bit count, tail/gap lengths and engine activity.
  task automatic run_frame(input logic [3:0] mask, input int id, input int dly, input int len,
                           input int und, input int ext, input logic [15:0] bits,
                           input string name);
    bit         to;
    int         s, kk, vv, gend, endr;
    logic [1:0] gi;
    logic [3:0] ge;
    logic       ve, ce, de, eue, ete;
    to   = (dly >= 15);
    s    = 1 + dly;
    kk   = (und > 0) ? und : len;
    vv   = s + kk;
    gend = to ? 15 : ((und > 0) ? vv : vv - 1);
    endr = to ? 16 : vv + 37 + ext;
    gi   = 2'(id);
    ptr_m = (id + 1) % N;
    i_req = mask;
    i_eng_out_vld = 1'b0;
    set_lanes(gi, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 1; r <= endr; r++) begin
      @(negedge i_clk);
      ge  = (r <= gend) ? 4'(1 << id) : 4'b0000;
      ve  = !to && (r > s) && (r <= vv);
      ce  = ve ? bits[4'(r - s - 1)] : 1'b0;
      de  = !to && (r == endr);
      eue = (und > 0) && (r == vv + 1);
      ete = to && (r == 16);
      if (de) begin
        prev_id_m   = id;
        prev_bits_m = kk;
      end
      check_out(name, ge, ve, ce, (r < endr), de, eue, ete, prev_id_m, prev_bits_m);
      if (r < endr) begin
        i_req = 4'($urandom);
        i_eng_out_vld = !to && (r >= vv) && (r <= vv + 35 + ext);
        if (to || r < s)
          set_lanes(gi, 1'b0, 1'($urandom), 1'($urandom), 1'b1);
        else if (r < s + kk)
          set_lanes(gi, 1'b1, bits[4'(r - s)], (und == 0) && (r == s + len - 1), 1'b1);
        else if ((und > 0) && (r == vv))
          set_lanes(gi, 1'b0, 1'b0, 1'b0, 1'b1);
        else
          set_lanes(gi, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    i_eng_out_vld = 1'b0;
  endtask

  initial begin
    logic [3:0] mask;
    logic [1:0] gi;
    int         id, sel, dly, len, und, ext;

    tbl[0]  = '{4'b1011, 1,  4, 0, 0,  16'h000A, 0, "rr_0"};
    tbl[1]  = '{4'b1011, 0,  4, 0, 0,  16'h0005, 1, "rr_1"};
    tbl[2]  = '{4'b1011, 2,  4, 0, 0,  16'h000C, 3, "rr_3"};
    tbl[3]  = '{4'b1011, 0,  4, 0, 0,  16'h0003, 0, "rr_0b"};
    tbl[4]  = '{4'b0100, 0,  8, 0, 0,  16'h00CD, 2, "single"};
    tbl[5]  = '{4'b0010, 15, 4, 0, 0,  16'h0000, 1, "timeout"};
    tbl[6]  = '{4'b1010, 0,  3, 0, 0,  16'h0005, 3, "after_to"};
    tbl[7]  = '{4'b0001, 1,  9, 5, 0,  16'h01B7, 0, "underrun"};
    tbl[8]  = '{4'b1000, 0,  3, 0, 10, 16'h0006, 3, "eng_hold"};
    tbl[9]  = '{4'b0010, 14, 2, 0, 0,  16'h0002, 1, "late_start"};
    tbl[10] = '{4'b0100, 3,  1, 0, 0,  16'h0001, 2, "one_bit"};
    tbl[11] = '{4'b1001, 0,  4, 1, 2,  16'h000F, 3, "underrun_1"};

    repeat (2) @(negedge i_clk);
    check_out("in_reset", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_out("reset_state", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    for (int t = 0; t < 12; t++)
      run_frame(tbl[t].mask, tbl[t].exp_id, tbl[t].dly, tbl[t].len, tbl[t].und, tbl[t].ext,
                tbl[t].bits, tbl[t].name);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
      mask = 4'($urandom_range(1, 15));
      sel  = int'($urandom_range(0, 9));
      if (sel < 7)      dly = int'($urandom_range(0, 3));
      else if (sel < 9) dly = int'($urandom_range(10, 14));
      else              dly = int'($urandom_range(15, 17));
      len = int'($urandom_range(1, 12));
      und = (len > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, len - 1)) : 0;
      ext = int'($urandom_range(0, 3));
      run_frame(mask, rr_pick(mask), dly, len, und, ext, 16'($urandom), "rand");
    end

    // Asynchronous reset in the middle of DATA, then requester 0 must beat requester 3.
    mask = 4'b1001;
    id   = rr_pick(mask);
    gi   = 2'(id);
    i_req = mask;
    set_lanes(gi, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge i_clk);
    check_out("mid_gnt", 4'(1 << id), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, prev_id_m, prev_bits_m);
    set_lanes(gi, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      @(negedge i_clk);
      check_out("mid_data", 4'(1 << id), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, prev_id_m, prev_bits_m);
      set_lanes(gi, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    #2 i_rst_n = 1'b0;
    #1 check_out("async_rst", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    i_bit_vld = '0;
    i_bit = '0;
    i_bit_last = '0;
    @(negedge i_clk);
    check_out("rst_hold", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    ptr_m = 0;
    prev_id_m = 0;
    prev_bits_m = 0;
    run_frame(4'b1001, 0, 0, 3, 0, 0, 16'h0006, "post_rst");
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
